fstat_calc: RTL



---
 rtl/fstat_calc_if.sv | 31 +++
 rtl/fstat_calc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fstat_calc_if.sv
// Handshake bundle for the window-statistics normaliser.
// The consumer drives start/fsum/f2sum; the results come back on the same bundle.
interface fstat_calc_if #(
    parameter int NPIX_LOG2 = 8,
    parameter int FS_W      = 11,
    parameter int F2_W      = 14
);
    localparam int VAR_W  = 2 * FS_W;
    localparam int MEAN_W = FS_W - NPIX_LOG2;

    logic              start_i;
    logic [FS_W-1:0]   fsum_i;
    logic [F2_W-1:0]   f2sum_i;
    logic              busy_o;
    logic              done_o;
    logic [MEAN_W-1:0] mean_o;
    logic [VAR_W-1:0]  var_o;
    logic [FS_W-1:0]   stddev_o;
    logic              err_o;
    logic              drop_o;

    modport master (
        output start_i, fsum_i, f2sum_i,
        input  busy_o, done_o, mean_o, var_o, stddev_o, err_o, drop_o
    );

    modport slave (
        input  start_i, fsum_i, f2sum_i,
        output busy_o, done_o, mean_o, var_o, stddev_o, err_o, drop_o
    );
endinterface

// File: rtl/fstat_calc.sv
// Window mean / scaled variance / stddev via shift-add square and restoring sqrt.
// Optional: define FSTAT_MEAN_ROUND_EN for rounded (saturating) mean.
module fstat_calc #(
    parameter int NPIX_LOG2 = 8,
    parameter int FS_W      = 11,
    parameter int F2_W      = 14
) (
    input  logic         clk,
    input  logic         rst,
    fstat_calc_if.slave  bus
);
    localparam int VAR_W  = 2 * FS_W;
    localparam int MEAN_W = FS_W - NPIX_LOG2;
    localparam int CNT_W  = $clog2(FS_W + 1);
    localparam int REM_W  = FS_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUARE,
        S_SUB,
        S_SQRT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FS_W-1:0]   fs_q, fs_d;
    logic [F2_W-1:0]   f2_q, f2_d;
    logic [VAR_W-1:0]  mcand_q, mcand_d;
    logic [FS_W-1:0]   mplier_q, mplier_d;
    logic [VAR_W-1:0]  prod_q, prod_d;
    logic [VAR_W-1:0]  vint_q, vint_d;
    logic              eint_q, eint_d;
    logic [VAR_W-1:0]  rad_q, rad_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [FS_W-1:0]   root_q, root_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [MEAN_W-1:0] mean_q, mean_d;
    logic [VAR_W-1:0]  var_q, var_d;
    logic [FS_W-1:0]   sd_q, sd_d;
    logic              err_q, err_d;

    logic [VAR_W:0]    f2_scaled;
    logic [VAR_W:0]    diff;
    logic [REM_W-1:0]  rem_sh;
    logic [REM_W-1:0]  trial;
    logic              ge;
    logic [MEAN_W-1:0] mean_calc;

    // Both operands are below 2^VAR_W, so the extra MSB acts as the sign.
    assign f2_scaled = (VAR_W + 1)'(f2_q) << NPIX_LOG2;
    assign diff      = f2_scaled - {1'b0, prod_q};

    assign rem_sh = {rem_q[REM_W-3:0], rad_q[VAR_W-1 -: 2]};
    assign trial  = {1'b0, root_q, 2'b01};
    assign ge     = rem_sh >= trial;

`ifdef FSTAT_MEAN_ROUND_EN
    logic [FS_W:0]     mean_sum;
    logic [MEAN_W:0]   mean_wide;
    assign mean_sum  = {1'b0, fs_q} + (FS_W + 1)'(1 << (NPIX_LOG2 - 1));
    assign mean_wide = mean_sum[FS_W:NPIX_LOG2];
    assign mean_calc = mean_wide[MEAN_W] ? '1 : mean_wide[MEAN_W-1:0];
`else
    assign mean_calc = fs_q[FS_W-1:NPIX_LOG2];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fs_d     = fs_q;
        f2_d     = f2_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        vint_d   = vint_q;
        eint_d   = eint_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        done_d   = 1'b0;
        drop_d   = bus.start_i && (state_q != S_IDLE);
        mean_d   = mean_q;
        var_d    = var_q;
        sd_d     = sd_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    fs_d     = bus.fsum_i;
                    f2_d     = bus.f2sum_i;
                    mcand_d  = VAR_W'(bus.fsum_i);
                    mplier_d = bus.fsum_i;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_SQUARE;
                end
            end
            S_SQUARE: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(FS_W - 1)) begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                vint_d  = diff[VAR_W] ? '0 : diff[VAR_W-1:0];
                eint_d  = diff[VAR_W];
                rad_d   = diff[VAR_W] ? '0 : diff[VAR_W-1:0];
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                rem_d  = ge ? rem_sh - trial : rem_sh;
                root_d = {root_q[FS_W-2:0], ge};
                rad_d  = rad_q << 2;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(FS_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                mean_d  = mean_calc;
                var_d   = vint_q;
                sd_d    = root_q;
                err_d   = eint_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fs_q     <= '0;
            f2_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            vint_q   <= '0;
            eint_q   <= 1'b0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            mean_q   <= '0;
            var_q    <= '0;
            sd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fs_q     <= fs_d;
            f2_q     <= f2_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            vint_q   <= vint_d;
            eint_q   <= eint_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
            mean_q   <= mean_d;
            var_q    <= var_d;
            sd_q     <= sd_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = done_q;
    assign bus.drop_o   = drop_q;
    assign bus.mean_o   = mean_q;
    assign bus.var_o    = var_q;
    assign bus.stddev_o = sd_q;
    assign bus.err_o    = err_q;
endmodule
